// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command frame assembler.
// Frame on the wire: HDR, P0, P1, P2, CHK where CHK = HDR ^ P0 ^ P1 ^ P2.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHKWAIT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int         FRAME_PAYLOAD = 3;
    localparam logic [7:0] HDR_DEFAULT   = 8'hA5;

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer: counts cycles while 'run' is high, flags the last allowed cycle.
// 'clear' has priority over 'run'.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TW          = $clog2(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run & (count_q == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles HDR,P0,P1,P2,CHK command frames from the UART RX byte stream and
// offers the payload to the command decoder over a valid/ready handshake.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HDR         = HDR_DEFAULT,
    parameter int          TIMEOUT_CYC = 50000,
    parameter int          TW          = $clog2(TIMEOUT_CYC)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_b0,
    output logic [7:0] out_b1,
    output logic [7:0] out_b2,
    output logic       err_chk,
    output logic       err_timeout,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    localparam logic [1:0] LAST_PAYLOAD = 2'(FRAME_PAYLOAD - 1);

    state_t     state_q, state_d;
    logic [7:0] r0_q, r1_q, r2_q;
    logic [7:0] chk_q, chk_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] drop_q, drop_d;
    logic       errChk_q, errChk_d;
    logic       errTo_q, errTo_d;
    logic       shiftEn;
    logic       timerRun;
    logic       timerClear;
    logic       timerExpired;

    // The timer only runs on idle cycles inside a frame; any byte or leaving the frame resets it.
    assign timerRun   = ((state_q == COLLECT) || (state_q == CHKWAIT)) && !rx_valid;
    assign timerClear = !timerRun;

    frame_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TW          (TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timerClear),
        .run     (timerRun),
        .expired (timerExpired)
    );

    always_comb begin
        state_d  = state_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        errChk_d = 1'b0;
        errTo_d  = 1'b0;
        shiftEn  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == HDR)) begin
                    state_d = COLLECT;
                    chk_d   = HDR;
                    cnt_d   = 2'd0;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    shiftEn = 1'b1;
                    chk_d   = chk_q ^ rx_data;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == LAST_PAYLOAD) begin
                        state_d = CHKWAIT;
                    end
                end else if (timerExpired) begin
                    errTo_d = 1'b1;
                    state_d = IDLE;
                end
            end
            CHKWAIT: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        state_d = HOLD;
                    end else begin
                        errChk_d = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (timerExpired) begin
                    errTo_d = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (rx_valid && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            chk_q    <= 8'h00;
            cnt_q    <= 2'd0;
            drop_q   <= 8'h00;
            errChk_q <= 1'b0;
            errTo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            errChk_q <= errChk_d;
            errTo_q  <= errTo_d;
        end
    end

    // Payload storage is never cleared between frames, only overwritten by new shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_q <= 8'h00;
            r1_q <= 8'h00;
            r2_q <= 8'h00;
        end else if (shiftEn) begin
            r0_q <= rx_data;
            r1_q <= r0_q;
            r2_q <= r1_q;
        end
    end

    assign out_b0      = r2_q;
    assign out_b1      = r1_q;
    assign out_b2      = r0_q;
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign err_chk     = errChk_q;
    assign err_timeout = errTo_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed and random stimulus for uart_frame_ctrl, compared every cycle against
// a frame-level reference model built from queues of received bytes.
module tb_uart_frame_ctrl;

    localparam int         TO  = 20;
    localparam logic [7:0] HDR = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_b0, out_b1, out_b2;
    logic       err_chk, err_timeout, busy;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    bit         mInFrame, mHolding, mErrChk, mErrTo;
    logic [7:0] mPay[$];
    logic [7:0] mHist[$];
    int         mIdle, mDrop;

    uart_frame_ctrl #(
        .HDR         (HDR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_b0      (out_b0),
        .out_b1      (out_b1),
        .out_b2      (out_b2),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] payloadXor();
        logic [7:0] x = HDR;
        foreach (mPay[i]) x = x ^ mPay[i];
        return x;
    endfunction

    task automatic modelReset();
        mInFrame = 0;
        mHolding = 0;
        mErrChk  = 0;
        mErrTo   = 0;
        mIdle    = 0;
        mDrop    = 0;
        mPay.delete();
        mHist = '{8'h00, 8'h00, 8'h00};
    endtask

    // One clock of the reference model, applied with the inputs present at that edge.
    task automatic modelStep(input bit v, input logic [7:0] d, input bit rdy);
        mErrChk = 0;
        mErrTo  = 0;
        if (mHolding) begin
            if (v && mDrop < 255) mDrop++;
            if (rdy) mHolding = 0;
        end else if (!mInFrame) begin
            if (v && d == HDR) begin
                mInFrame = 1;
                mIdle    = 0;
                mPay.delete();
            end
        end else if (v) begin
            mIdle = 0;
            if (mPay.size() < 3) begin
                mPay.push_back(d);
                mHist.push_back(d);
                void'(mHist.pop_front());
            end else begin
                mInFrame = 0;
                if (d == payloadXor()) mHolding = 1;
                else mErrChk = 1;
            end
        end else if (mIdle == TO - 1) begin
            mErrTo   = 1;
            mInFrame = 0;
        end else begin
            mIdle++;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("out_valid", {31'd0, out_valid}, {31'd0, mHolding});
        checkVal("out_b", {8'd0, out_b0, out_b1, out_b2}, {8'd0, mHist[0], mHist[1], mHist[2]});
        checkVal("err_chk", {31'd0, err_chk}, {31'd0, mErrChk});
        checkVal("err_timeout", {31'd0, err_timeout}, {31'd0, mErrTo});
        checkVal("drop_cnt", {24'd0, drop_cnt}, 32'(mDrop));
        checkVal("busy", {31'd0, busy}, {31'd0, (mInFrame | mHolding)});
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit rdy);
        @(negedge clk);
        rx_valid  = v;
        rx_data   = d;
        out_ready = rdy;
        @(posedge clk);
        modelStep(v, d, rdy);
        #1;
        checkOutput();
    endtask

    task automatic sendFrame(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] c, input bit rdy);
        applyStimulus(1, h, rdy);
        applyStimulus(1, p0, rdy);
        applyStimulus(1, p1, rdy);
        applyStimulus(1, p2, rdy);
        applyStimulus(1, c, rdy);
    endtask

    initial begin
        logic [7:0] d;
        bit         v;
        modelReset();
        #3;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Good frame with the consumer always ready
        sendFrame(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5, 1);
        checkVal("good_valid", {31'd0, out_valid}, 32'd1);
        checkVal("good_b", {8'd0, out_b0, out_b1, out_b2}, 32'h00123456);
        applyStimulus(0, 8'h00, 1);
        checkVal("good_busy_after", {31'd0, busy}, 32'd0);

        // Bad checksum, then a frame whose checksum equals HDR
        sendFrame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h00, 1);
        checkVal("bad_errchk", {31'd0, err_chk}, 32'd1);
        applyStimulus(0, 8'h00, 1);
        sendFrame(8'hA5, 8'h01, 8'h02, 8'h03, 8'hA5, 1);
        checkVal("chkA5_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(0, 8'h00, 1);

        // Timeout after TO idle cycles, and survival with TO-1 idle cycles
        applyStimulus(1, 8'hA5, 1);
        applyStimulus(1, 8'h12, 1);
        repeat (TO) applyStimulus(0, 8'h00, 1);
        checkVal("timeout_pulse", {31'd0, err_timeout}, 32'd1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(1, 8'hA5, 1);
        applyStimulus(1, 8'h12, 1);
        repeat (TO - 1) applyStimulus(0, 8'h00, 1);
        applyStimulus(1, 8'h34, 1);
        checkVal("expiry_byte_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1, 8'h56, 1);
        repeat (TO - 1) applyStimulus(0, 8'h00, 1);
        applyStimulus(1, 8'hD5, 1);
        checkVal("expiry_frame_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(0, 8'h00, 1);

        // Backpressure with drops while held
        sendFrame(8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 0);
        for (int i = 0; i < 10; i++) applyStimulus((i % 3) == 1, 8'($urandom), 0);
        checkVal("bp_drops", {24'd0, drop_cnt}, 32'd3);
        checkVal("bp_stable", {8'd0, out_b0, out_b1, out_b2}, 32'h00112233);
        applyStimulus(0, 8'h00, 1);
        checkVal("bp_release", {31'd0, busy}, 32'd0);

        // Header hunt with HDR bytes inside the payload
        applyStimulus(1, 8'h00, 1);
        applyStimulus(1, 8'hFF, 1);
        sendFrame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1);
        checkVal("hunt_errchk", {31'd0, err_chk}, 32'd1);
        applyStimulus(1, 8'h00, 1);
        applyStimulus(1, 8'hFF, 1);
        sendFrame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 1);
        checkVal("hunt_b", {8'd0, out_b0, out_b1, out_b2}, 32'h00A5A5A5);
        applyStimulus(0, 8'h00, 1);

        // Drop counter saturation
        sendFrame(8'hA5, 8'h01, 8'h02, 8'h03, 8'hA5, 0);
        repeat (260) applyStimulus(1, 8'h5A, 0);
        checkVal("drop_sat", {24'd0, drop_cnt}, 32'h000000FF);
        applyStimulus(1, 8'h5A, 1);

        // Asynchronous reset between edges while collecting
        applyStimulus(1, 8'hA5, 1);
        applyStimulus(1, 8'h12, 1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkVal("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(0, 8'h00, 1);

        // Random traffic with occasional long gaps and deliberate correct checksums
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                repeat (TO + 2) applyStimulus(0, 8'h00, $urandom_range(0, 1) == 1);
            end
            v = ($urandom_range(0, 99) < 45);
            if (mInFrame && mPay.size() == 3 && $urandom_range(0, 1) == 1) d = payloadXor();
            else if ($urandom_range(0, 99) < 30) d = HDR;
            else d = 8'($urandom);
            applyStimulus(v, d, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Sequences a 3-deep byte shift register to assemble fixed-format command frames from the UART receiver byte stream. The frame format is HDR, P0, P1, P2, CHK.
It hunts for the header byte, shifts in three payload bytes, checks an XOR checksum, and enforces an inter-byte timeout. It then presents the frame to the command decoder over a valid/ready handshake.
It sits between the UART RX block and the command decoder / 7-seg byte display.

Parameters:
HDR, 8'hA5, frame header byte.
TIMEOUT_CYC, 50000, idle clock cycles allowed between bytes inside a frame (1 ms at 50 MHz); must be at least 2.
TW, $clog2(TIMEOUT_CYC), timer width (derived, do not override).

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
rx_data  in  8  received byte from UART RX.
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
out_valid  out  1  assembled frame available.
out_ready  in  1  consumer accepts frame when high with out_valid.
out_b0  out  8  first payload byte (P0).
out_b1  out  8  second payload byte (P1).
out_b2  out  8  third payload byte (P2).
err_chk  out  1  one-cycle pulse: checksum mismatch.
err_timeout  out  1  one-cycle pulse: inter-byte timeout.
drop_cnt  out  8  bytes dropped while a frame is held; saturates at 8'hFF.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - Storage regs r0..r2, chk accumulator, byte counter, timer and drop_cnt are all 0.
  - All outputs are 0.
- Storage: a 3-stage byte shift register.
  - On a shift: r0<=rx_data, r1<=r0, r2<=r1.
  - out_b0=r2, out_b1=r1, out_b2=r0; the outputs are always driven from the registers.
  - Storage is not cleared between frames; it is overwritten.
- States: IDLE, COLLECT, CHKWAIT, HOLD.
- IDLE:
  - rx_valid with rx_data==HDR -> COLLECT; chk<=HDR, cnt<=0, timer<=0.
  - Any other byte is ignored silently, with no error.
- COLLECT:
  - rx_valid -> shift; chk<=chk^rx_data; cnt<=cnt+1; timer<=0.
  - Shift of the 3rd payload byte (cnt==2) -> CHKWAIT.
  - A byte equal to HDR inside the payload is treated as data.
- CHKWAIT:
  - rx_valid with rx_data==chk -> HOLD.
  - rx_valid with rx_data!=chk -> err_chk pulse next cycle, then IDLE. Storage keeps the bad payload.
- Timeout (COLLECT and CHKWAIT):
  - The timer increments on every cycle without rx_valid.
  - When the timer==TIMEOUT_CYC-1 and rx_valid=0 -> err_timeout pulse next cycle, then IDLE.
  - rx_valid on the expiry cycle wins: the byte is processed and the timer cleared.
- HOLD:
  - out_valid=1 starting the cycle after the CHK byte is accepted (1-cycle latency).
  - out_b* stay stable while held.
  - out_valid&out_ready -> IDLE; out_valid is 0 the next cycle.
  - The timer does not run in HOLD.
- Drops in HOLD:
  - Every rx_valid in HOLD, including the handshake cycle, is dropped and drop_cnt increments, saturating at FF.
  - drop_cnt is cleared only by reset.
- Error pulses: err_chk and err_timeout are registered, exactly 1 cycle wide, and never both high.
- busy = (state!=IDLE).
- Reset mid-frame: immediate return to IDLE with everything cleared; the partial frame is lost and no error pulses are issued.

Decomposition:
- Package uart_frame_pkg holds:
  - state_t enum (IDLE, COLLECT, CHKWAIT, HOLD);
  - localparam FRAME_PAYLOAD=3;
  - default HDR constant 8'hA5.
- One sub-module: frame_timeout_timer, with ports clk, rst_n, clear, run, expired, parameterised by TIMEOUT_CYC.
  - expired is combinational: run & (count==TIMEOUT_CYC-1).
- The shift register stays inline in uart_frame_ctrl, because this block needs an async reset and gated shift under FSM control.

Test Plan:
1. Good frame: A5,12,34,56,D5 with out_ready=1 -> out_valid for 1 cycle, the cycle after D5. out_b0=12, out_b1=34, out_b2=56. No error pulses; busy drops after the handshake.
2. Bad checksum: A5,12,34,56,00 -> err_chk single pulse, state IDLE, out_valid never high. A following A5,01,02,03,A5 frame is accepted (chk=A5).
3. Timeout (TIMEOUT_CYC=20): A5,12, then 20 idle cycles -> err_timeout pulse. A byte arriving exactly on cycle 19 instead is accepted and no timeout occurs.
4. Backpressure: good frame with out_ready=0 for 10 cycles while 3 bytes arrive -> out_b* stable, drop_cnt=3. Raising out_ready then returns to IDLE.
5. Header hunt: 00,FF,A5,A5,A5,A5,A5 -> HDR accepted at the 3rd byte. Payload is A5,A5,A5; chk=A5^A5^A5^A5=00, so the CHK byte A5 gives err_chk. The same sequence with a final 00 yields out_b0..b2=A5.
6. Async reset mid-COLLECT, asserted between clock edges -> outputs and busy go 0 immediately, drop_cnt=0, and no error pulse after release.
